data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the single-cycle core's data-memory port. Decodes the core's address, write enable and write data, and returns read data in the same cycle.
- Provides three targets: a word-addressed RAM, a free-running timer with a compare interrupt, and a to-host output FIFO with a valid/ready drain port.
- Sits beside the core at SoC top level; instruction memory is a separate block.

Parameters:
- RAM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4, to-host FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_mem_write_enable  in  1  store strobe from core.
- ALUResult  in  32  byte address from core.
- data_mem_write_data  in  32  store data.
- data_mem_read_data  out  32  load data, combinational from address.
- host_valid  out  1  FIFO head valid.
- host_data  out  32  FIFO head word.
- host_ready  in  1  host accepts head.
- timer_irq  out  1  registered, mtime >= mtimecmp (unsigned).
- addr_fault  out  1  one-cycle pulse, registered; write to an unmapped address.

Behaviour:
- Address map, full 32-bit compare. ALUResult[1:0] is ignored everywhere; word access only.
  - 0x0000_0000 .. RAM_WORDS*4-1: RAM, indexed by ALUResult[log2(RAM_WORDS)+1:2].
  - 0x1000_0000 MTIME: read/write.
  - 0x1000_0004 MTIMECMP: read/write.
  - 0x1000_0008 TOHOST: write pushes to FIFO; read returns 0.
  - 0x1000_000C STATUS: read returns {full, overflow, 24'b0, count[5:0]}; a write of any value clears overflow.
  - Any other address: read returns 0; a write is dropped and pulses addr_fault.
- Reads: combinational, zero latency. A RAM write becomes visible from the next cycle. A read of the address being written in the same cycle returns the old value.
- RAM: synchronous write when data_mem_write_enable is high and the address is in range. Contents are not reset.
- Timer:
  - mtime increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - A write to MTIME loads the written value; the write wins over the increment that cycle.
  - timer_irq register <= (mtime_next >= mtimecmp_next), so it reflects writes one cycle after the write.
- FIFO:
  - Push = write to TOHOST. Pop = host_valid && host_ready.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push sets sticky overflow and leaves data unchanged.
  - A STATUS-write clear and an overflow in the same cycle: set wins.
  - host_valid = (count != 0). host_data = head entry, stable while host_valid && !host_ready.
  - Empty FIFO with push: data appears on host_data the next cycle, never same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is 0..FIFO_DEPTH; full = (count == FIFO_DEPTH).
- Reset (asynchronous, any time including mid-drain):
  - mtime = 0, mtimecmp = 0xFFFF_FFFF, timer_irq = 0.
  - FIFO empty, host_valid = 0, host_data = 0, overflow = 0, addr_fault = 0.
  - RAM retained. Outputs are valid from the first edge after deassertion.

Decomposition:
- Add to riscv_pkg:
  - address constants MMIO_BASE, MTIME_ADDR, MTIMECMP_ADDR, TOHOST_ADDR, STATUS_ADDR.
  - an enum for the decoded target: TGT_RAM, TGT_MTIME, TGT_MTIMECMP, TGT_TOHOST, TGT_STATUS, TGT_NONE.
- Sub-module tohost_fifo:
  - Parameter DEPTH.
  - Ports: push, push_data, pop, head, count, full, overflow, clr_overflow.
  - Instantiated once.
- Address decode, RAM and timer stay in the top.

Test Plan:
- RAM path: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0013 next cycle -> 0xDEADBEEF. Read 0x0000_0010 during the write cycle -> prior value.
- Timer interrupt: after reset, write MTIMECMP = 20 and MTIME = 15 -> timer_irq rises exactly 5 cycles after the MTIME write is applied. Write MTIMECMP = 0xFFFF_FFFF -> timer_irq low one cycle later.
- FIFO fill and drain:
  - With host_ready = 0, push 1, 2, 3, 4, 5 -> STATUS reads full = 1, overflow = 1, count = 4.
  - Then host_ready = 1 -> host_data sequence 1, 2, 3, 4, then host_valid = 0.
  - A STATUS write then clears overflow.
- Simultaneous push and pop when full: count 4, host_ready = 1, push 9 -> accepted, count stays 4, overflow stays 0, 9 emerges last.
- Unmapped write: write to 0x2000_0000 -> addr_fault high for exactly one cycle. RAM, timer and FIFO are unchanged. A read of that address returns 0.
- Mid-operation reset: assert reset asynchronously while the FIFO holds 3 entries and mtime = 100 -> host_valid = 0, mtime = 0 and timer_irq = 0 immediately. After release, RAM word written earlier still reads back.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the data-memory responder.
//   - MMIO address constants for the timer and to-host FIFO registers.
//   - tgt_e: the decoded target of a data-memory access.
//   - decode_addr(): maps a byte address to its target.
//     The comparison uses the full word address, and bits [1:0] are ignored.
package riscv_pkg;

  localparam logic [31:0] MMIO_BASE     = 32'h1000_0000;
  localparam logic [31:0] MTIME_ADDR    = MMIO_BASE + 32'h0;
  localparam logic [31:0] MTIMECMP_ADDR = MMIO_BASE + 32'h4;
  localparam logic [31:0] TOHOST_ADDR   = MMIO_BASE + 32'h8;
  localparam logic [31:0] STATUS_ADDR   = MMIO_BASE + 32'hC;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_MTIME,
    TGT_MTIMECMP,
    TGT_TOHOST,
    TGT_STATUS,
    TGT_NONE
  } tgt_e;

  // ram_bytes is a multiple of 4, so the low address bits cannot change the
  // outcome of the RAM range test.
  function automatic tgt_e decode_addr(input logic [31:0] addr,
                                       input logic [32:0] ram_bytes);
    tgt_e t;
    t = TGT_NONE;
    if ({1'b0, addr} < ram_bytes)                   t = TGT_RAM;
    else if (addr[31:2] == MTIME_ADDR[31:2])        t = TGT_MTIME;
    else if (addr[31:2] == MTIMECMP_ADDR[31:2])     t = TGT_MTIMECMP;
    else if (addr[31:2] == TOHOST_ADDR[31:2])       t = TGT_TOHOST;
    else if (addr[31:2] == STATUS_ADDR[31:2])       t = TGT_STATUS;
    return t;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: the core/host side of the data-memory responder.
//   Core -> responder : data_mem_write_enable, ALUResult, data_mem_write_data
//   Responder -> core : data_mem_read_data (combinational)
//   Responder -> host : host_valid, host_data, timer_irq, addr_fault
//   Host -> responder : host_ready
// Modports:
//   master : the core and host side that drives requests.
//   slave  : the responder.
interface data_mem_responder_if;
  logic        data_mem_write_enable;
  logic [31:0] ALUResult;
  logic [31:0] data_mem_write_data;
  logic [31:0] data_mem_read_data;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        timer_irq;
  logic        addr_fault;

  modport master (
    output data_mem_write_enable, ALUResult, data_mem_write_data, host_ready,
    input  data_mem_read_data, host_valid, host_data, timer_irq, addr_fault
  );

  modport slave (
    input  data_mem_write_enable, ALUResult, data_mem_write_data, host_ready,
    output data_mem_read_data, host_valid, host_data, timer_irq, addr_fault
  );
endinterface

// File: rtl/tohost_fifo.sv
// tohost_fifo: a small first-word-fall-through FIFO that carries words to the host.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset.
//   push         : request to write push_data.
//   push_data    : data to write.
//   pop          : the head has been consumed.
//   head         : the head entry; it is 0 while the FIFO is empty.
//   count        : number of entries held, 0..DEPTH.
//   full         : count == DEPTH.
//   overflow     : sticky flag, set when a push is rejected.
//   clr_overflow : clears overflow. If a rejection happens in the same cycle, the set wins.
module tohost_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow,
  input  logic          clr_overflow
);

  logic [31:0]   fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop_ok, push_ok;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still
  // accepted when a pop happens alongside it.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q < CW'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
    overflow_d = overflow_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !push_ok)  overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The storage is not reset. The head is gated to 0 while the FIFO is empty,
  // so its stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= push_data;
  end

  assign head     = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : 32'h0;
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign overflow = overflow_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: the responder end of the core's data-memory port.
// Targets:
//   - Word RAM at 0 .. RAM_WORDS*4-1.
//   - MTIME and MTIMECMP timer registers.
//   - TOHOST FIFO push register.
//   - STATUS register.
// Reads are combinational. Writes take effect on the rising edge.
// Ports:
//   clk, reset : clock and asynchronous active-high reset.
//   bus        : data_mem_responder_if.slave, which carries:
//                - the core request (write enable, ALUResult, write data) and the read data;
//                - the host drain port (host_valid, host_data, host_ready);
//                - timer_irq and addr_fault.
module data_mem_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);
  import riscv_pkg::*;

  localparam int              AW        = $clog2(RAM_WORDS);
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0]     RAM_BYTES = 33'(RAM_WORDS) << 2;

  tgt_e           tgt;
  logic           we;
  logic [31:0]    wdata;
  logic [AW-1:0]  ram_idx;
  logic           wr_ram, wr_mtime, wr_mtimecmp, wr_tohost, wr_status, wr_none;

  assign we      = bus.data_mem_write_enable;
  assign wdata   = bus.data_mem_write_data;
  assign tgt     = decode_addr(bus.ALUResult, RAM_BYTES);
  assign ram_idx = bus.ALUResult[AW+1:2];

  assign wr_ram      = we && (tgt == TGT_RAM);
  assign wr_mtime    = we && (tgt == TGT_MTIME);
  assign wr_mtimecmp = we && (tgt == TGT_MTIMECMP);
  assign wr_tohost   = we && (tgt == TGT_TOHOST);
  assign wr_status   = we && (tgt == TGT_STATUS);
  assign wr_none     = we && (tgt == TGT_NONE);

  // ---------------- RAM (contents survive reset) ----------------
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= wdata;
  end

  // ---------------- Timer ----------------
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic        timer_irq_q, timer_irq_d;
  logic        addr_fault_q, addr_fault_d;

  always_comb begin
    mtime_d      = wr_mtime ? wdata : mtime_q + 32'd1;  // a write beats the increment
    mtimecmp_d   = wr_mtimecmp ? wdata : mtimecmp_q;
    // Compare against the next-state values, so a register write shows up on
    // the interrupt one cycle later.
    timer_irq_d  = (mtime_d >= mtimecmp_d);
    addr_fault_d = wr_none;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q      <= 32'h0;
      mtimecmp_q   <= 32'hFFFF_FFFF;
      timer_irq_q  <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      timer_irq_q  <= timer_irq_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  // ---------------- To-host FIFO ----------------
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_overflow, fifo_pop, fifo_valid;
  logic [5:0]    count6;

  assign fifo_valid = (fifo_count != '0);
  assign fifo_pop   = fifo_valid && bus.host_ready;

  tohost_fifo #(.DEPTH(FIFO_DEPTH)) u_tohost_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (wr_tohost),
    .push_data    (wdata),
    .pop          (fifo_pop),
    .head         (fifo_head),
    .count        (fifo_count),
    .full         (fifo_full),
    .overflow     (fifo_overflow),
    .clr_overflow (wr_status)
  );

  // The STATUS count field is 6 bits wide whatever the FIFO depth.
  generate
    if (CW >= 6) begin : g_cnt_trunc
      assign count6 = fifo_count[5:0];
    end else begin : g_cnt_ext
      assign count6 = {{(6 - CW){1'b0}}, fifo_count};
    end
  endgenerate

  // ---------------- Read mux ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'h0;
    case (tgt)
      TGT_RAM:      rdata = ram_q[ram_idx];
      TGT_MTIME:    rdata = mtime_q;
      TGT_MTIMECMP: rdata = mtimecmp_q;
      TGT_STATUS:   rdata = {fifo_full, fifo_overflow, 24'b0, count6};
      default:      rdata = 32'h0;   // TOHOST and unmapped addresses read as 0
    endcase
  end

  assign bus.data_mem_read_data = rdata;
  assign bus.host_valid         = fifo_valid;
  assign bus.host_data          = fifo_head;
  assign bus.timer_irq          = timer_irq_q;
  assign bus.addr_fault         = addr_fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Words expected on the host port
// go into a scoreboard queue when they are pushed. They are popped and
// compared when the host accepts a word.
module tb_data_mem_responder;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.ALUResult             = addr;
    bus.data_mem_write_data   = data;
    bus.data_mem_write_enable = 1'b1;
    tick();
    bus.data_mem_write_enable = 1'b0;
    $display("wr   addr=%h data=%h", addr, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.ALUResult             = addr;
    bus.data_mem_write_enable = 1'b0;
    #1;
    data = bus.data_mem_read_data;
    $display("rd   addr=%h data=%h", addr, data);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && bus.host_valid === 1'b1; i++) tick();
    check_val("drain_done", 32'(bus.host_valid), 32'd0);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Host-side monitor: a word is consumed on every edge where valid and ready are both high.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.host_valid === 1'b1 && bus.host_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("pop  data=%h exp=%h", bus.host_data, e);
        check_val("host_data", bus.host_data, e);
      end
    end
  end

  initial begin
    bus.data_mem_write_enable = 1'b0;
    bus.ALUResult             = 32'h0;
    bus.data_mem_write_data   = 32'h0;
    bus.host_ready            = 1'b0;
    reset                     = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_host_valid", 32'(bus.host_valid), 32'd0);
    check_val("rst_host_data", bus.host_data, 32'h0);
    check_val("rst_irq", 32'(bus.timer_irq), 32'd0);
    check_val("rst_addr_fault", 32'(bus.addr_fault), 32'd0);
    bus_read(MTIME_ADDR, rd);    check_val("rst_mtime", rd, 32'h0);
    bus_read(MTIMECMP_ADDR, rd); check_val("rst_mtimecmp", rd, 32'hFFFF_FFFF);
    bus_read(STATUS_ADDR, rd);   check_val("rst_status", rd, 32'h0);
    reset = 1'b0;
    tick();

    // ---- RAM path ----
    bus_write(32'h0000_0010, 32'h1111_1111);
    bus.ALUResult             = 32'h0000_0010;
    bus.data_mem_write_data   = 32'hDEAD_BEEF;
    bus.data_mem_write_enable = 1'b1;
    #1;
    check_val("ram_old_during_write", bus.data_mem_read_data, 32'h1111_1111);
    tick();
    bus.data_mem_write_enable = 1'b0;
    bus_read(32'h0000_0013, rd); check_val("ram_readback", rd, 32'hDEAD_BEEF);

    // ---- timer interrupt ----
    bus_write(MTIMECMP_ADDR, 32'd20);
    bus_write(MTIME_ADDR, 32'd15);
    check_val("irq_k0", 32'(bus.timer_irq), 32'd0);
    bus_read(MTIME_ADDR, rd); check_val("mtime_loaded", rd, 32'd15);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_val("irq_early", 32'(bus.timer_irq), 32'd0);
    end
    tick();
    check_val("irq_rise", 32'(bus.timer_irq), 32'd1);
    bus_write(MTIMECMP_ADDR, 32'hFFFF_FFFF);
    check_val("irq_fall", 32'(bus.timer_irq), 32'd0);

    // ---- FIFO fill with overflow, then drain ----
    for (int v = 1; v <= 5; v++) begin
      bus_write(TOHOST_ADDR, 32'(v));
      if (v <= 4) exp_q.push_back(32'(v));
    end
    check_val("fill_valid", 32'(bus.host_valid), 32'd1);
    check_val("fill_head", bus.host_data, 32'd1);
    bus_read(STATUS_ADDR, rd); check_val("status_full_ovf", rd, 32'hC000_0004);
    bus_read(TOHOST_ADDR, rd); check_val("tohost_read0", rd, 32'h0);
    bus.host_ready = 1'b1;
    wait_drain(20);
    bus.host_ready = 1'b0;
    bus_read(STATUS_ADDR, rd); check_val("status_ovf_sticky", rd, 32'h4000_0000);
    bus_write(STATUS_ADDR, 32'h1234_5678);
    bus_read(STATUS_ADDR, rd); check_val("status_cleared", rd, 32'h0);

    // ---- simultaneous push and pop while full ----
    for (int v = 5; v <= 8; v++) begin
      bus_write(TOHOST_ADDR, 32'(v));
      exp_q.push_back(32'(v));
    end
    bus_read(STATUS_ADDR, rd); check_val("status_full", rd, 32'h8000_0004);
    bus.ALUResult             = TOHOST_ADDR;
    bus.data_mem_write_data   = 32'd9;
    bus.data_mem_write_enable = 1'b1;
    bus.host_ready            = 1'b1;
    exp_q.push_back(32'd9);
    tick();
    bus.data_mem_write_enable = 1'b0;
    bus.host_ready            = 1'b0;
    bus_read(STATUS_ADDR, rd); check_val("status_pushpop", rd, 32'h8000_0004);
    check_val("head_after_pushpop", bus.host_data, 32'd6);
    bus.host_ready = 1'b1;
    wait_drain(20);
    bus.host_ready = 1'b0;

    // ---- unmapped write ----
    bus.ALUResult             = 32'h2000_0000;
    bus.data_mem_write_data   = 32'h1234_5678;
    bus.data_mem_write_enable = 1'b1;
    #1;
    check_val("unmapped_read", bus.data_mem_read_data, 32'h0);
    tick();
    bus.data_mem_write_enable = 1'b0;
    check_val("fault_pulse", 32'(bus.addr_fault), 32'd1);
    tick();
    check_val("fault_clear", 32'(bus.addr_fault), 32'd0);
    bus_read(32'h0000_0010, rd); check_val("unmapped_ram_kept", rd, 32'hDEAD_BEEF);
    bus_read(MTIMECMP_ADDR, rd); check_val("unmapped_cmp_kept", rd, 32'hFFFF_FFFF);
    bus_read(STATUS_ADDR, rd);   check_val("unmapped_fifo_kept", rd, 32'h0);

    // ---- mid-operation asynchronous reset ----
    bus_write(MTIMECMP_ADDR, 32'd50);
    for (int v = 10; v <= 12; v++) begin
      bus_write(TOHOST_ADDR, 32'(v));
      exp_q.push_back(32'(v));
    end
    bus_write(MTIME_ADDR, 32'd100);
    check_val("pre_rst_irq", 32'(bus.timer_irq), 32'd1);
    bus_read(MTIME_ADDR, rd); check_val("pre_rst_mtime", rd, 32'd100);
    check_val("pre_rst_valid", 32'(bus.host_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_val("arst_valid", 32'(bus.host_valid), 32'd0);
    check_val("arst_data", bus.host_data, 32'h0);
    check_val("arst_irq", 32'(bus.timer_irq), 32'd0);
    bus_read(MTIME_ADDR, rd); check_val("arst_mtime", rd, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    bus_read(32'h0000_0010, rd); check_val("ram_retained", rd, 32'hDEAD_BEEF);
    bus_read(STATUS_ADDR, rd);   check_val("post_rst_status", rd, 32'h0);
    bus_read(MTIMECMP_ADDR, rd); check_val("post_rst_cmp", rd, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
